// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream -> 32-bit LE word writes; core held in reset until loaded.
// Latency: mem_we one cycle after a word's 4th byte; in_ready low outside LEN_LO/LEN_HI/DATA, so the source holds bytes.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_run,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q, word_d;
    logic [15:0] words_q, words_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] words_inc;

    assign in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign xfer      = in_valid && in_ready;
    assign len_full  = {in_data, len_q[7:0]};
    assign words_inc = words_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    words_d = 16'd0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_full} > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_DATA;
                        byte_cnt_d = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = in_data;
                        2'd1: word_d[15:8]  = in_data;
                        2'd2: word_d[23:16] = in_data;
                        default: begin
                            // Lane 3 goes straight into the write register; no need to store it.
                            mem_we_d    = 1'b1;
                            mem_addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
                            mem_wdata_d = {in_data, word_q};
                            state_d     = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                words_d = words_inc;
                state_d = (words_inc == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= 16'd0;
            byte_cnt_q  <= 2'd0;
            word_q      <= 24'd0;
            words_q     <= 16'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_run     = (state_q == S_DONE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign words_loaded = words_q;

    // The write strobe is registered alongside the state, so the two must always agree.
    a_we_in_write: assert property (@(posedge clk) disable iff (!reset)
        mem_we_q == (state_q == S_WRITE));
    a_words_bound: assert property (@(posedge clk) disable iff (!reset)
        (state_q == S_DATA || state_q == S_WRITE) |-> words_q < len_q);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and 0x1000) share one randomized stream; a queue-based model checks writes.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;

    logic        rdy0, we0, run0, done0, err0;
    logic [31:0] addr0, wd0;
    logic [15:0] wl0;
    logic        rdy1, we1, run1, done1, err1;
    logic [31:0] addr1, wd1;
    logic [15:0] wl1;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    wr_t wq0[$];
    wr_t wq1[$];
    int  xq[$];

    always #5 clk = ~clk;

    imem_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .core_run(run0), .done(done0), .error(err0), .words_loaded(wl0));

    imem_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_1000)) dut1 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .core_run(run1), .done(done1), .error(err1), .words_loaded(wl1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && in_valid && rdy0) xq.push_back(cyc);
        if (we0) begin
            wq0.push_back('{addr0, wd0, cyc});
            chk("rdy_in_write", 32'(rdy0), 32'd0);
        end
        if (we1) wq1.push_back('{addr1, wd1, cyc});
    end

    task automatic send_bytes(input byte_q_t b, input int mode, input bit stray);
        int idx = 0;
        int guard = 0;
        bit tog = 1'b1;
        while (idx < b.size() && guard < 20000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = !tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? b[idx] : 8'($urandom);
            start   = stray && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (in_valid && rdy0) idx++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("stream_consumed", 32'(idx), 32'(b.size()));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("arm_done", 32'(done0), 32'd0);
        chk("arm_run", 32'(run0), 32'd0);
        chk("arm_err", 32'(err0), 32'd0);
        chk("arm_wl", 32'(wl0), 32'd0);
        chk("arm_rdy", 32'(rdy0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic byte_q_t rand_words(input int n);
        byte_q_t q;
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic run_load(input int len, input byte_q_t d, input int mode, input bit stray);
        byte_q_t s;
        int n_exp;
        bit exp_err;
        int g = 0;
        logic [31:0] w;
        wq0.delete();
        wq1.delete();
        xq.delete();
        exp_err = (len > 256);
        n_exp   = (len == 0 || exp_err) ? 0 : len;
        s.push_back(8'(len));
        s.push_back(8'(len >> 8));
        for (int i = 0; i < 4 * n_exp; i++) s.push_back(d[i]);
        pulse_start();
        send_bytes(s, mode, stray);
        @(negedge clk);
        while (!(done0 || err0) && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("end_done", 32'(done0), 32'(!exp_err));
        chk("end_run", 32'(run0), 32'(!exp_err));
        chk("end_err", 32'(err0), 32'(exp_err));
        chk("end_done1", 32'(done1), 32'(!exp_err));
        chk("end_err1", 32'(err1), 32'(exp_err));
        chk("end_wl", 32'(wl0), 32'(n_exp));
        chk("end_wl1", 32'(wl1), 32'(n_exp));
        chk("end_rdy", 32'(rdy0), 32'd0);
        chk("nwrites0", 32'(wq0.size()), 32'(n_exp));
        chk("nwrites1", 32'(wq1.size()), 32'(n_exp));
        for (int k = 0; k < n_exp && k < wq0.size() && k < wq1.size(); k++) begin
            w = {d[4*k+3], d[4*k+2], d[4*k+1], d[4*k]};
            chk("addr0", wq0[k].addr, 32'(4 * k));
            chk("data0", wq0[k].data, w);
            chk("addr1", wq1[k].addr, 32'h1000 + 32'(4 * k));
            chk("data1", wq1[k].data, w);
            if (4 * k + 5 < xq.size()) begin
                chk("lat0", 32'(wq0[k].cyc), 32'(xq[4*k+5] + 1));
                chk("lat1", 32'(wq1[k].cyc), 32'(xq[4*k+5] + 1));
            end else begin
                chk("xfer_count", 32'(xq.size()), 32'(4 * k + 6));
            end
        end
        if (n_exp > 0) chk("addr_hold", addr0, 32'(4 * (n_exp - 1)));
    endtask

    initial begin
        byte_q_t basic;
        byte_q_t empty;
        byte_q_t part;
        basic = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

        // Reset with start and valid active must leave everything at zero.
        reset = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(rdy0), 32'd0);
        chk("rst_we", 32'(we0), 32'd0);
        chk("rst_addr", addr0, 32'd0);
        chk("rst_wdata", wd0, 32'd0);
        chk("rst_run", 32'(run0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_wl", 32'(wl0), 32'd0);
        chk("rst_addr1", addr1, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rdy", 32'(rdy0), 32'd0);
            chk("idle_run", 32'(run0), 32'd0);
        end
        chk("idle_nwrites", 32'(wq0.size()), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        run_load(2, basic, 0, 1'b0);
        chk("basic_word0", wd0 == 32'h0020_0593 ? 32'd1 : 32'd0, 32'd1);
        run_load(2, basic, 1, 1'b0);
        run_load(0, empty, 0, 1'b0);
        run_load(257, empty, 0, 1'b0);
        run_load(256, rand_words(256), 0, 1'b0);
        run_load(1, rand_words(1), 2, 1'b0);
        run_load(3, rand_words(3), 0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 12);
            run_load(n, rand_words(n), 2, 1'b1);
        end
        run_load(16'hFFFF, empty, 2, 1'b1);

        // Abort with reset after one word plus two bytes of the next.
        wq0.delete();
        pulse_start();
        part = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_bytes(part, 0, 1'b0);
        @(negedge clk);
        chk("abort_pre_writes", 32'(wq0.size()), 32'd1);
        chk("abort_pre_wl", 32'(wl0), 32'd1);
        @(posedge clk);
        #1;
        wq0.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        @(negedge clk);
        chk("abort_wl", 32'(wl0), 32'd0);
        chk("abort_rdy", 32'(rdy0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("abort_nwrites", 32'(wq0.size()), 32'd0);
        chk("abort_run", 32'(run0), 32'd0);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the core's read-only instruction memory.
- Receives a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one write strobe per word into the instruction memory write port.
- Holds the core in reset until the program image is fully loaded.

Parameters:
- MAX_WORDS, 256: largest accepted program length in words; legal range 1..65535.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR; ignored in other states.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready at a rising edge.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of the word being written.
- mem_wdata  output  32  assembled word.
- core_run  output  1  0 holds the core in reset; 1 releases it.
- done  output  1  load completed successfully (level).
- error  output  1  length rejected (level).
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - in_ready, mem_we, core_run, done and error go to 0.
  - mem_addr, mem_wdata, words_loaded and the internal length/byte counters go to 0.
  - Reset during any state aborts the load immediately; no further mem_we is issued.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE: in_ready=0, core_run=0. When start=1, go to LEN_LO and clear words_loaded.
- LEN_LO: in_ready=1. On transfer, len[7:0]=in_data; go to LEN_HI.
- LEN_HI: in_ready=1. On transfer, len[15:8]=in_data, then:
  - len==0: go to DONE; no writes are issued.
  - len>MAX_WORDS: go to ERR.
  - Otherwise: go to DATA with byte_cnt=0.
- DATA: in_ready=1.
  - On transfer, in_data goes into word byte lane byte_cnt (byte 0 = bits 7:0, little-endian), and byte_cnt increments mod 4.
  - On the transfer with byte_cnt==3, go to WRITE.
  - Without in_valid, hold indefinitely; no timeout.
- WRITE: exactly one cycle.
  - in_ready=0, mem_we=1.
  - mem_addr = BASE_ADDR + 4*words_loaded, using the pre-increment value.
  - mem_wdata = assembled word.
  - On exit, words_loaded increments. If the new words_loaded==len, go to DONE; otherwise go to DATA.
- Registered outputs:
  - mem_we, mem_addr and mem_wdata are registered and valid together in the WRITE cycle.
  - mem_we is 0 in every other state.
  - mem_addr and mem_wdata hold their last values outside WRITE.
- Latency: mem_we asserts in the cycle immediately after the 4th byte of a word is accepted. Peak throughput is 4 bytes per 5 cycles.
- DONE: core_run=1, done=1, in_ready=0. The state persists until start or reset.
- ERR: error=1, core_run=0, in_ready=0. The state persists until start or reset.
- Re-arm: start in DONE or ERR goes to LEN_LO. In the same cycle it clears done, error, core_run and words_loaded.
- start in LEN_LO, LEN_HI, DATA or WRITE is ignored.
- Bytes presented while in_ready=0 are not consumed; the source must hold them.
- Address arithmetic is 32-bit modulo 2^32. words_loaded is 16 bits and never exceeds len.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 and start=1 -> all outputs 0, state IDLE, no mem_we. Release -> remains IDLE until start.
- Basic load: start, then bytes 02 00 13 05 10 00 93 05 20 00 with in_valid held high.
  - Required writes: mem_we at addr 0x0 with 0x00100513, then at addr 0x4 with 0x00200593.
  - Then done=1, core_run=1, words_loaded=2.
  - Exactly 2 mem_we pulses, each one cycle after the 4th byte of its word.
- Backpressure and gaps: same stream with in_valid toggling every other cycle -> identical writes and data.
  - Bench also checks in_ready=0 during the WRITE cycle, and that a byte offered then is accepted in the next DATA cycle.
- Length bounds (MAX_WORDS=256):
  - Length 00 00 -> done=1 with no mem_we.
  - Length 01 01 (257) -> error=1, core_run=0, no mem_we.
  - Length 00 01 (256) -> 256 writes, final addr 0x3FC.
- Re-arm and abort:
  - start from DONE -> done and core_run drop the next cycle, and a new 1-word load completes.
  - reset=0 asserted mid-word (after 2 data bytes) -> IDLE, no further writes, words_loaded=0.
- BASE_ADDR=32'h0000_1000: 3-word load -> writes to 0x1000, 0x1004 and 0x1008 in order.
